rv32i_fetch_decode: RTL and testbench

Multi-cycle fetch/decode/sequencing stage sitting directly upstream of the RV32I datapath. Fetches one instruction over a req/ack instruction-memory port, decodes it into the 23-bit control word, immediate and PC the datapath consumes, and holds them stable for a fixed issue window. Resolves branches, JAL and JALR from register values read back from the datapath, then advances the PC.

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/rv32i_fetch_decode_if.sv | 10 +
 rtl/rv32i_imm_gen.sv | 24 ++
 rtl/rv32i_fetch_decode.sv | 185 ++++++++++++++++++
 tb/tb_rv32i_fetch_decode.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch/decode stage.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CWORD_W = 23;
    localparam int unsigned TYPE_W  = 4;
    localparam int unsigned FUN3_W  = 3;
    localparam int unsigned REG_W   = 5;

    // instType codes carried in cword[3:0]
    localparam logic [TYPE_W-1:0] IT_LOAD  = 4'd0;
    localparam logic [TYPE_W-1:0] IT_IMM   = 4'd1;
    localparam logic [TYPE_W-1:0] IT_STORE = 4'd2;
    localparam logic [TYPE_W-1:0] IT_REG   = 4'd3;
    localparam logic [TYPE_W-1:0] IT_LUI   = 4'd4;
    localparam logic [TYPE_W-1:0] IT_AUIPC = 4'd5;
    localparam logic [TYPE_W-1:0] IT_BRNCH = 4'd6;
    localparam logic [TYPE_W-1:0] IT_JALR  = 4'd7;
    localparam logic [TYPE_W-1:0] IT_JAL   = 4'd8;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Control word layout: [22:18] rs2, [17:13] rs1, [12:8] rd, [7] fun7, [6:4] fun3, [3:0] instType
    typedef struct packed {
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rd;
        logic              fun7;
        logic [FUN3_W-1:0] fun3;
        logic [TYPE_W-1:0] itype;
    } cword_t;

    // Branch with all fields zero: the datapath writes nothing
    localparam cword_t CWORD_BUBBLE = cword_t'(23'h000006);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_TRAP   = 3'd4
    } fd_state_t;

endpackage

// File: rtl/rv32i_fetch_decode_if.sv
// Instruction-memory req/ack port.
interface rv32i_fetch_decode_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational instruction -> sign-extended immediate, format chosen by opcode.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm_c
);

    // Pick I/S/B/U/J layout; R-type and unknown opcodes give zero
    always_comb begin
        imm_c = '0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_c = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRNCH:                 imm_c = {{19{instr[31]}}, instr[31], instr[7],
                                               instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm_c = {instr[31:12], 12'b0};
            OP_JAL:                   imm_c = {{11{instr[31]}}, instr[31], instr[19:12],
                                               instr[20], instr[30:21], 1'b0};
            default:                  imm_c = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_fetch_decode.sv
// RV32I fetch/decode/sequencing stage: fetch, decode, hold control word for
// ISSUE_CYCLES, resolve next PC, retire.
// Build option: RV32I_FD_ILLEGAL_TRAP_EN - illegal instructions trap instead of being skipped.
module rv32i_fetch_decode
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ISSUE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_fetch_decode_if.master imem,
    input  logic [31:0]          rs1_val,
    input  logic [31:0]          rs2_val,
    output logic [CWORD_W-1:0]   cword,
    output logic [31:0]          pc,
    output logic [31:0]          imm,
    output logic                 retire,
    output logic                 trap
);

    localparam int unsigned CNT_W = $clog2(ISSUE_CYCLES);

    fd_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       instr_q, instr_d;
    cword_t            cword_q, cword_d;
    logic [31:0]       pc_d, imm_d;
    logic              retire_d, trap_d;
    logic              req_q, req_d;

    cword_t            dec;
    logic              dec_legal;
    logic [31:0]       dec_imm_c;
    logic              taken;
    logic [31:0]       target;

    assign imem.req  = req_q;
    assign imem.addr = pc;
    assign cword     = cword_q;

    rv32i_imm_gen u_imm_gen (
        .instr (instr_q),
        .imm_c (dec_imm_c)
    );

    // Decode latched instruction; register fields the format does not encode are zeroed
    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        dec.fun3  = instr_q[14:12];
        dec.rd    = instr_q[11:7];
        dec.rs1   = instr_q[19:15];
        dec.rs2   = instr_q[24:20];
        case (instr_q[6:0])
            OP_LOAD:  begin dec.itype = IT_LOAD;  dec.rs2 = '0; end
            OP_IMM:   begin
                dec.itype = IT_IMM;
                dec.rs2   = '0;
                dec.fun7  = (instr_q[14:12] == 3'b101) ? instr_q[30] : 1'b0;
            end
            OP_STORE: begin dec.itype = IT_STORE; dec.rd = '0; end
            OP_REG:   begin dec.itype = IT_REG;   dec.fun7 = instr_q[30]; end
            OP_LUI:   begin dec.itype = IT_LUI;   dec.rs1 = '0; dec.rs2 = '0; end
            OP_AUIPC: begin dec.itype = IT_AUIPC; dec.rs1 = '0; dec.rs2 = '0; end
            OP_BRNCH: begin
                dec.itype = IT_BRNCH;
                dec.rd    = '0;
                dec_legal = (instr_q[14:13] != 2'b01);
            end
            OP_JALR:  begin dec.itype = IT_JALR;  dec.rs2 = '0; end
            OP_JAL:   begin dec.itype = IT_JAL;   dec.rs1 = '0; dec.rs2 = '0; end
            default:  begin dec = CWORD_BUBBLE;   dec_legal = 1'b0; end
        endcase
    end

    // Branch condition and next-PC target from the issued control word
    always_comb begin
        taken = 1'b0;
        case (cword_q.fun3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val <  rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
        target = pc + 32'd4;
        case (cword_q.itype)
            IT_JAL:   target = pc + imm;
            IT_JALR:  target = (rs1_val + imm) & ~32'd1;
            IT_BRNCH: if (taken) target = pc + imm;
            default:  ;
        endcase
    end

    // Sequencer next-state and registered-output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        cword_d  = cword_q;
        pc_d     = pc;
        imm_d    = imm;
        retire_d = 1'b0;
        trap_d   = trap;
        req_d    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                if (req_q && imem.ack) begin
                    instr_d = imem.rdata;
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    cword_d = dec;
                    imm_d   = dec_imm_c;
                    cnt_d   = CNT_W'(ISSUE_CYCLES - 1);
                    state_d = ST_ISSUE;
                end else begin
`ifdef RV32I_FD_ILLEGAL_TRAP_EN
                    trap_d   = 1'b1;
                    state_d  = ST_TRAP;
`else
                    pc_d     = pc + 32'd4;
                    retire_d = 1'b1;
                    state_d  = ST_UPDATE;
`endif
                end
            end
            ST_ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cword_d = CWORD_BUBBLE;
                    imm_d   = '0;
                    if (target[1]) begin
                        trap_d  = 1'b1;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d     = target;
                        retire_d = 1'b1;
                        state_d  = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                req_d   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            instr_q <= '0;
            cword_q <= CWORD_BUBBLE;
            pc      <= RESET_PC;
            imm     <= '0;
            retire  <= 1'b0;
            trap    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            cword_q <= cword_d;
            pc      <= pc_d;
            imm     <= imm_d;
            retire  <= retire_d;
            trap    <= trap_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_decode.sv
// Self-checking bench for rv32i_fetch_decode: directed vector table, reset
// corner sequences, and random instructions checked against a reference model.
module tb_rv32i_fetch_decode;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [22:0] BUBBLE   = 23'h000006;
`ifdef RV32I_FD_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] ins;
        int          dly;
        logic [31:0] r1;
        logic [31:0] r2;
        bit          legal;
        logic [22:0] cw;
        logic [31:0] im;
        logic [31:0] nxt;
        bit          tr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1_val, rs2_val;
    logic [22:0] cword;
    logic [31:0] pc, imm;
    logic        retire, trap;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mpc;

    rv32i_fetch_decode_if imem_bus();

    rv32i_fetch_decode #(.RESET_PC(RESET_PC), .ISSUE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .imem    (imem_bus),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .cword   (cword),
        .pc      (pc),
        .imm     (imm),
        .retire  (retire),
        .trap    (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (model pc %h)", name, act, exp, mpc);
        end
    endtask

    task automatic wait_req(output bit ok);
        int w;
        w = 0;
        while (imem_bus.req !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        ok = (imem_bus.req === 1'b1);
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_timeout: imem_req %b, expected 1", imem_bus.req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_bus.ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mpc = RESET_PC;
    endtask

    // Reference model: behaviour of one instruction derived from the ISA rules
    function automatic void model(input logic [31:0] ins, input logic [31:0] cur_pc,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  output bit legal, output logic [22:0] cw,
                                  output logic [31:0] im, output logic [31:0] nxt,
                                  output bit tr);
        logic [6:0]  opc_tab [9];
        int          t, v;
        logic [2:0]  f3;
        logic [4:0]  rd, a, b;
        logic        f7;
        bit          tk;
        logic [31:0] tgt;
        opc_tab = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F};
        t = -1;
        for (int i = 0; i < 9; i++)
            if (ins[6:0] == opc_tab[i]) t = i;
        f3    = ins[14:12];
        legal = (t >= 0) && !(t == 6 && (f3 == 3'b010 || f3 == 3'b011));
        v = 0;
        case (t)
            0, 1, 7: v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
            2:       v = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            6:       v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                         + int'(ins[11:8]) * 2;
            4, 5:    v = int'(ins & 32'hFFFFF000);
            8:       v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                         + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        im = 32'(v);
        rd = (t == 2 || t == 6) ? 5'd0 : ins[11:7];
        a  = (t == 4 || t == 5 || t == 8) ? 5'd0 : ins[19:15];
        b  = (t == 2 || t == 3 || t == 6) ? ins[24:20] : 5'd0;
        f7 = (t == 3 || (t == 1 && f3 == 3'b101)) ? ins[30] : 1'b0;
        cw = legal ? {b, a, rd, f7, f3, 4'(t)} : BUBBLE;
        if (!legal) begin
            tr  = TRAP_EN;
            nxt = tr ? cur_pc : cur_pc + 32'd4;
        end else begin
            tk = 1'b0;
            case (f3)
                3'd0: tk = (r1 == r2);
                3'd1: tk = (r1 != r2);
                3'd4: tk = ($signed(r1) <  $signed(r2));
                3'd5: tk = ($signed(r1) >= $signed(r2));
                3'd6: tk = (r1 <  r2);
                3'd7: tk = (r1 >= r2);
                default: tk = 1'b0;
            endcase
            tgt = cur_pc + 32'd4;
            if (t == 8)            tgt = cur_pc + im;
            else if (t == 7)       tgt = (r1 + im) & 32'hFFFFFFFE;
            else if (t == 6 && tk) tgt = cur_pc + im;
            tr  = tgt[1];
            nxt = tr ? cur_pc : tgt;
        end
    endfunction

    // Drive one instruction through fetch/decode/issue and check every phase
    task automatic exec(input logic [31:0] ins, input int dly,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input bit legal, input logic [22:0] ecw, input logic [31:0] eimm,
                        input logic [31:0] enext, input bit etrap);
        bit ok;
        wait_req(ok);
        if (ok) begin
            chk("fetch_addr", imem_bus.addr, mpc);
            for (int i = 0; i < dly; i++) begin
                imem_bus.ack = 1'b0;
                @(negedge clk);
                chk("addr_stable", imem_bus.addr, mpc);
                chk("req_held", 32'(imem_bus.req), 32'd1);
            end
            imem_bus.ack   = 1'b1;
            imem_bus.rdata = ins;
            rs1_val = $urandom;
            rs2_val = $urandom;
            @(negedge clk);
            imem_bus.ack   = 1'b0;
            imem_bus.rdata = $urandom;
            chk("decode_bubble", 32'(cword), 32'(BUBBLE));
            @(negedge clk);
            if (legal) begin
                for (int k = 0; k < 4; k++) begin
                    chk("issue_cword", 32'(cword), 32'(ecw));
                    chk("issue_imm", imm, eimm);
                    if (k == 0) begin
                        chk("issue_pc", pc, mpc);
                        rs1_val = r1;
                        rs2_val = r2;
                    end
                    @(negedge clk);
                end
            end
            if (etrap) begin
                chk("trap_set", 32'(trap), 32'd1);
                chk("trap_no_retire", 32'(retire), 32'd0);
                chk("trap_pc", pc, mpc);
                chk("trap_cword", 32'(cword), 32'(BUBBLE));
                repeat (3) @(negedge clk);
                chk("trap_req_low", 32'(imem_bus.req), 32'd0);
                chk("trap_sticky", 32'(trap), 32'd1);
            end else begin
                chk("retire", 32'(retire), 32'd1);
                chk("next_pc", pc, enext);
                chk("update_bubble", 32'(cword), 32'(BUBBLE));
                chk("no_trap", 32'(trap), 32'd0);
                mpc = enext;
                @(negedge clk);
                chk("retire_pulse", 32'(retire), 32'd0);
            end
        end
    endtask

    vec_t        tab [9];
    logic [6:0]  ops [10];
    logic [31:0] ins, r1, r2, enx, eim;
    logic [22:0] ecw;
    bit          lg, tr, ok;
    int          sel;

    initial begin
        rst = 1'b0;
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = '0;
        rs1_val = '0;
        rs2_val = '0;
        mpc = RESET_PC;

        tab[0] = '{32'h00500093, 0, 32'h0,   32'h0, 1'b1, 23'h000101, 32'd5,        32'h00000004, 1'b0};
        tab[1] = '{32'h00C0006F, 1, 32'h0,   32'h0, 1'b1, 23'h000008, 32'd12,       32'h00000010, 1'b0};
        tab[2] = '{32'h00208463, 0, 32'd7,   32'd7, 1'b1, 23'h082006, 32'd8,        32'h00000018, 1'b0};
        tab[3] = '{32'hFF9FF06F, 2, 32'h0,   32'h0, 1'b1, 23'h000078, 32'hFFFFFFF8, 32'h00000010, 1'b0};
        tab[4] = '{32'h00208463, 0, 32'd7,   32'd8, 1'b1, 23'h082006, 32'd8,        32'h00000014, 1'b0};
        tab[5] = '{32'h00C0006F, 0, 32'h0,   32'h0, 1'b1, 23'h000008, 32'd12,       32'h00000020, 1'b0};
        tab[6] = '{32'hFFFFFFFF, 3, 32'h0,   32'h0, 1'b0, BUBBLE,     32'd0,
                   TRAP_EN ? 32'h00000020 : 32'h00000024, TRAP_EN};
        tab[7] = '{32'h000280E7, 0, 32'h101, 32'h0, 1'b1, 23'h00A107, 32'd0,        32'h00000100, 1'b0};
        tab[8] = '{32'h000280E7, 1, 32'h103, 32'h0, 1'b1, 23'h00A107, 32'd0,        32'h00000100, 1'b1};
        ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F, 7'h7F};

        // Reset values, then imem_req rises one cycle after release
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_addr", imem_bus.addr, RESET_PC);
        chk("rst_req", 32'(imem_bus.req), 32'd0);
        chk("rst_cword", 32'(cword), 32'(BUBBLE));
        chk("rst_imm", imm, 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_bus.req), 32'd1);
        chk("post_rst_addr", imem_bus.addr, RESET_PC);
        chk("post_rst_cword", 32'(cword), 32'(BUBBLE));

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            exec(tab[i].ins, tab[i].dly, tab[i].r1, tab[i].r2, tab[i].legal,
                 tab[i].cw, tab[i].im, tab[i].nxt, tab[i].tr);
            if (tab[i].tr) do_reset();
        end

        // Reset mid-fetch with an ack in flight: the ack must be dropped
        wait_req(ok);
        rst = 1'b0;
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h00500093;
        @(negedge clk);
        chk("fetch_rst_req", 32'(imem_bus.req), 32'd0);
        rst = 1'b1;
        imem_bus.ack = 1'b0;
        mpc = RESET_PC;
        @(negedge clk);
        chk("fetch_rst_cword", 32'(cword), 32'(BUBBLE));
        exec(32'h00500093, 0, 32'h0, 32'h0, 1'b1, 23'h000101, 32'd5, RESET_PC + 32'd4, 1'b0);

        // Reset during ISSUE cycle 2 of a jal
        wait_req(ok);
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h00C0006F;
        @(negedge clk);
        imem_bus.ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("issue1_cword", 32'(cword), 32'h000008);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("issue_rst_pc", pc, RESET_PC);
        chk("issue_rst_cword", 32'(cword), 32'(BUBBLE));
        chk("issue_rst_retire", 32'(retire), 32'd0);
        chk("issue_rst_req", 32'(imem_bus.req), 32'd0);
        rst = 1'b1;
        mpc = RESET_PC;
        @(negedge clk);
        chk("issue_rst_retire2", 32'(retire), 32'd0);

        // Random instructions against the reference model
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 9);
            ins[6:0] = ops[sel];
            if (sel == 6 && $urandom_range(0, 3) != 0) ins[8]  = 1'b0;
            if (sel == 8 && $urandom_range(0, 3) != 0) ins[21] = 1'b0;
            r1 = $urandom;
            r2 = ($urandom_range(0, 2) == 0) ? r1 : 32'($urandom);
            model(ins, mpc, r1, r2, lg, ecw, eim, enx, tr);
            exec(ins, $urandom_range(0, 3), r1, r2, lg, ecw, eim, enx, tr);
            if (tr) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
